// File: rtl/multimode_counter_ctrl_pkg.sv
// Shared types and constants for the multimode counter session controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multimode_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] MODE_UP1 = 2'b00;
   localparam logic [1:0] MODE_UP2 = 2'b01;
   localparam logic [1:0] MODE_DN1 = 2'b10;
   localparam logic [1:0] MODE_DN2 = 2'b11;

   localparam logic [1:0] WHO_WIN  = 2'b01;
   localparam logic [1:0] WHO_LOSE = 2'b10;

   // Pick the 2-bit mode for a schedule step; step 0 lives in bits [1:0].
   function automatic logic [1:0] step_mode(input logic [7:0] seq, input logic [1:0] step);
      return seq[{step, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/multimode_counter_ctrl_if.sv
// Host-side and counter-side signal bundle for the session controller.
// Latency: n/a (wiring only).
// Backpressure: none; the controller owns all master outputs, which are registered.
interface multimode_counter_ctrl_if #(
   parameter int CNT_W   = 4,
   parameter int TALLY_W = 4
);
   // host side
   logic               start;
   logic               abort;
   logic [CNT_W-1:0]   seed;
   logic [7:0]         mode_seq;
   logic [TALLY_W-1:0] win_tally;
   logic [TALLY_W-1:0] lose_tally;
   logic               busy;
   logic               done;
   logic [1:0]         result;
   logic               mismatch;
   // counter side
   logic [1:0]         ctr_ctrl;
   logic               ctr_init;
   logic [CNT_W-1:0]   ctr_init_value;
   logic               ctr_winner;
   logic               ctr_loser;
   logic               ctr_gameover;
   logic [1:0]         ctr_who;
   logic [CNT_W-1:0]   ctr_count;

   modport master (
      input  start, abort, seed, mode_seq,
      input  ctr_winner, ctr_loser, ctr_gameover, ctr_who, ctr_count,
      output ctr_ctrl, ctr_init, ctr_init_value,
      output win_tally, lose_tally, busy, done, result, mismatch
   );

   modport slave (
      output start, abort, seed, mode_seq,
      output ctr_winner, ctr_loser, ctr_gameover, ctr_who, ctr_count,
      input  ctr_ctrl, ctr_init, ctr_init_value,
      input  win_tally, lose_tally, busy, done, result, mismatch
   );

endinterface

// File: rtl/multimode_counter_ctrl_sat_tally.sv
// Saturating event tally with synchronous clear (clear wins over increment).
// Latency: 1 cycle from clr_i/inc_i to tally_o.
// Backpressure: none; increments at all-ones are dropped.
module sat_tally #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] tally_o
);

   logic [W-1:0] tally_q;
   logic [W-1:0] tally_d;

   // Next value: clear, else count up until all-ones and stick there.
   always_comb begin
      tally_d = tally_q;
      if (clr_i) begin
         tally_d = '0;
      end else if (inc_i && (tally_q != {W{1'b1}})) begin
         tally_d = tally_q + W'(1);
      end
   end

   // Tally register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tally_q <= '0;
      end else begin
         tally_q <= tally_d;
      end
   end

   assign tally_o = tally_q;

endmodule

// File: rtl/multimode_counter_ctrl.sv
// Session controller: loads the counter, walks a 4-step mode schedule, tallies outcomes, reports result.
// Latency: start -> ctr_init next cycle; gameover -> done two cycles later.
// Backpressure: none; start outside IDLE is dropped, abort overrides everything but rst.
module multimode_counter_ctrl
   import multimode_pkg::*;
#(
   parameter int CNT_W       = 4,
   parameter int MODE_CYCLES = 16,
   parameter int TALLY_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   multimode_counter_ctrl_if.master bus
);

   localparam logic [7:0] DWELL_LAST = 8'(MODE_CYCLES - 1);

   state_t           state_q;
   logic [7:0]       mode_seq_q;
   logic [1:0]       step_q;
   logic [1:0]       step_d;
   logic [7:0]       dwell_q;
   logic [7:0]       dwell_d;
   logic [1:0]       ctr_ctrl_q;
   logic             ctr_init_q;
   logic [CNT_W-1:0] ctr_init_value_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       result_q;
   logic             mismatch_q;

   logic tally_clr;
   logic win_inc;
   logic lose_inc;

   // Schedule position for the next RUN cycle: dwell counts cycles within a step.
   always_comb begin
      step_d  = step_q;
      dwell_d = dwell_q + 8'd1;
      if (dwell_q == DWELL_LAST) begin
         dwell_d = '0;
         step_d  = step_q + 2'd1;
      end
   end

   // Tallies clear on an accepted start and only count live RUN-cycle pulses.
   assign tally_clr = (state_q == IDLE) && bus.start && !bus.abort;
   assign win_inc   = (state_q == RUN) && bus.ctr_winner && !bus.abort;
   assign lose_inc  = (state_q == RUN) && bus.ctr_loser  && !bus.abort;

   // Session FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         mode_seq_q       <= '0;
         step_q           <= '0;
         dwell_q          <= '0;
         ctr_ctrl_q       <= MODE_UP1;
         ctr_init_q       <= 1'b0;
         ctr_init_value_q <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         result_q         <= 2'b00;
         mismatch_q       <= 1'b0;
      end else if (bus.abort) begin
         state_q    <= IDLE;
         ctr_ctrl_q <= MODE_UP1;
         ctr_init_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  mode_seq_q       <= bus.mode_seq;
                  ctr_init_value_q <= bus.seed;
                  ctr_init_q       <= 1'b1;
                  ctr_ctrl_q       <= MODE_UP1;
                  busy_q           <= 1'b1;
                  result_q         <= 2'b00;
                  mismatch_q       <= 1'b0;
                  state_q          <= LOAD;
               end
            end
            LOAD: begin
               ctr_init_q <= 1'b0;
               step_q     <= 2'd0;
               dwell_q    <= 8'd0;
               ctr_ctrl_q <= step_mode(mode_seq_q, 2'd0);
               state_q    <= RUN;
            end
            RUN: begin
               if (bus.ctr_winner && bus.ctr_loser) begin
                  mismatch_q <= 1'b1;
               end
               if (bus.ctr_gameover) begin
                  // mode bus holds through DRAIN
                  state_q <= DRAIN;
               end else begin
                  step_q     <= step_d;
                  dwell_q    <= dwell_d;
                  ctr_ctrl_q <= step_mode(mode_seq_q, step_d);
               end
            end
            DRAIN: begin
               result_q <= bus.ctr_who;
               if ((bus.ctr_who != WHO_WIN) && (bus.ctr_who != WHO_LOSE)) begin
                  mismatch_q <= 1'b1;
               end
               ctr_ctrl_q <= MODE_UP1;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state_q    <= DONE;
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   sat_tally #(.W(TALLY_W)) u_win_tally (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (tally_clr),
      .inc_i   (win_inc),
      .tally_o (bus.win_tally)
   );

   sat_tally #(.W(TALLY_W)) u_lose_tally (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (tally_clr),
      .inc_i   (lose_inc),
      .tally_o (bus.lose_tally)
   );

   assign bus.ctr_ctrl       = ctr_ctrl_q;
   assign bus.ctr_init       = ctr_init_q;
   assign bus.ctr_init_value = ctr_init_value_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.result         = result_q;
   assign bus.mismatch       = mismatch_q;

endmodule

// File: tb/tb_multimode_counter_ctrl.sv
// Bench for multimode_counter_ctrl: directed and random sessions against a scoreboard.
// Latency: expectations queued by stimulus, popped by a negedge monitor on DUT outputs.
// Backpressure: n/a; the bench plays host and counter stub.
module tb_multimode_counter_ctrl;

   localparam int CNT_W   = 4;
   localparam int MC      = 4;
   localparam int TALLY_W = 4;
   localparam int TMAX    = (1 << TALLY_W) - 1;

   typedef struct {
      logic       done;
      int         win;
      int         lose;
      logic [1:0] result;
      logic       mm;
   } end_t;

   logic clk;
   logic rst;

   multimode_counter_ctrl_if #(.CNT_W(CNT_W), .TALLY_W(TALLY_W)) bus ();

   multimode_counter_ctrl #(
      .CNT_W       (CNT_W),
      .MODE_CYCLES (MC),
      .TALLY_W     (TALLY_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [CNT_W-1:0] exp_load[$];
   logic [1:0]       exp_ctrl[$];
   end_t             exp_end[$];

   logic ev_win  [64];
   logic ev_lose [64];
   logic prev_busy = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Monitor: every DUT-visible event pops the matching expectation.
   always @(negedge clk) begin
      logic [CNT_W-1:0] s;
      logic [1:0]       m;
      end_t             e;
      if (bus.ctr_init) begin
         if (exp_load.size() == 0) begin
            flag("unexpected_load");
         end else begin
            s = exp_load.pop_front();
            chk("load_value", int'(bus.ctr_init_value), int'(s));
            chk("load_ctrl", int'(bus.ctr_ctrl), 0);
            chk("load_busy", int'(bus.busy), 1);
         end
      end else if (bus.busy) begin
         if (exp_ctrl.size() == 0) begin
            flag("unexpected_busy_cycle");
         end else begin
            m = exp_ctrl.pop_front();
            chk("run_ctrl", int'(bus.ctr_ctrl), int'(m));
         end
      end
      if (prev_busy && !bus.busy) begin
         if (exp_end.size() == 0) begin
            flag("unexpected_session_end");
         end else begin
            e = exp_end.pop_front();
            chk("end_done", int'(bus.done), int'(e.done));
            chk("end_win_tally", int'(bus.win_tally), e.win);
            chk("end_lose_tally", int'(bus.lose_tally), e.lose);
            chk("end_result", int'(bus.result), int'(e.result));
            chk("end_mismatch", int'(bus.mismatch), int'(e.mm));
            chk("end_ctrl", int'(bus.ctr_ctrl), 0);
            chk("end_init", int'(bus.ctr_init), 0);
         end
      end else if (bus.done) begin
         flag("unexpected_done");
      end
      prev_busy = bus.busy;
   end

   task automatic clear_events();
      for (int i = 0; i < 64; i++) begin
         ev_win[i]  = 1'b0;
         ev_lose[i] = 1'b0;
      end
   endtask

   // One session. endk: 0 gameover, 1 abort in last RUN cycle, 2 reset in last RUN cycle.
   // Called at #1 after a rising edge with the DUT in IDLE.
   task automatic run_session(input logic [CNT_W-1:0] sd, input logic [7:0] ms,
                              input int nrun, input int endk, input logic [1:0] who);
      int   w;
      int   l;
      logic mm;
      int   md;
      end_t e;
      w  = 0;
      l  = 0;
      mm = 1'b0;
      md = 0;
      exp_load.push_back(sd);
      bus.start    = 1'b1;
      bus.seed     = sd;
      bus.mode_seq = ms;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < nrun; k++) begin
         if ((k == nrun - 1) && (endk == 2)) begin
            e = '{done: 1'b0, win: 0, lose: 0, result: 2'b00, mm: 1'b0};
            exp_end.push_back(e);
            rst = 1'b1;
            #1;
            chk("reset_init_value", int'(bus.ctr_init_value), 0);
            chk("reset_busy", int'(bus.busy), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         // schedule step for RUN cycle k is (k / MC) mod 4
         md = (k / MC) % 4;
         exp_ctrl.push_back(ms[2*md +: 2]);
         bus.ctr_winner = ev_win[k];
         bus.ctr_loser  = ev_lose[k];
         bus.start      = ($urandom_range(0, 3) == 0);
         if ((k == nrun - 1) && (endk == 1)) begin
            bus.abort = 1'b1;
            bus.start = 1'b1;
         end else begin
            if (ev_win[k])  w++;
            if (ev_lose[k]) l++;
            if (ev_win[k] && ev_lose[k]) mm = 1'b1;
         end
         if ((k == nrun - 1) && (endk == 0)) begin
            bus.ctr_gameover = 1'b1;
            bus.ctr_who      = who;
         end
         @(posedge clk); #1;
      end
      bus.ctr_winner   = 1'b0;
      bus.ctr_loser    = 1'b0;
      bus.ctr_gameover = 1'b0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      if (w > TMAX) w = TMAX;
      if (l > TMAX) l = TMAX;
      if (endk == 1) begin
         e = '{done: 1'b0, win: w, lose: l, result: 2'b00, mm: mm};
         exp_end.push_back(e);
      end else begin
         exp_ctrl.push_back(ms[2*md +: 2]);
         if ((who != 2'b01) && (who != 2'b10)) mm = 1'b1;
         e = '{done: 1'b1, win: w, lose: l, result: who, mm: mm};
         exp_end.push_back(e);
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      bus.ctr_who = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         nrun;
      int         endk;
      logic [1:0] who;
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.seed         = '0;
      bus.mode_seq     = '0;
      bus.ctr_winner   = 1'b0;
      bus.ctr_loser    = 1'b0;
      bus.ctr_gameover = 1'b0;
      bus.ctr_who      = 2'b00;
      bus.ctr_count    = '0;
      clear_events();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", int'(bus.ctr_ctrl), 0);
      chk("rst_init", int'(bus.ctr_init), 0);
      chk("rst_init_value", int'(bus.ctr_init_value), 0);
      chk("rst_win", int'(bus.win_tally), 0);
      chk("rst_lose", int'(bus.lose_tally), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_result", int'(bus.result), 0);
      chk("rst_mismatch", int'(bus.mismatch), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // basic load, full mode rotation with wrap, 3 wins / 1 loss, winner result
      clear_events();
      ev_win[1] = 1'b1; ev_win[3] = 1'b1; ev_win[5] = 1'b1; ev_lose[8] = 1'b1;
      run_session(4'd10, 8'b11_10_01_00, 20, 0, 2'b01);

      // saturation: 20 winner pulses
      clear_events();
      for (int i = 0; i < 20; i++) ev_win[i] = 1'b1;
      run_session(4'd3, 8'b00_01_10_11, 22, 0, 2'b10);

      // winner and loser together: sticky mismatch
      clear_events();
      ev_win[2] = 1'b1; ev_lose[2] = 1'b1; ev_win[6] = 1'b1;
      run_session(4'd7, 8'b01_01_10_10, 10, 0, 2'b01);

      // illegal who at gameover
      clear_events();
      ev_lose[0] = 1'b1;
      run_session(4'd15, 8'b10_11_00_01, 5, 0, 2'b11);

      // abort in RUN with a winner pulse on the abort cycle
      clear_events();
      ev_win[1] = 1'b1; ev_lose[3] = 1'b1; ev_win[8] = 1'b1;
      run_session(4'd5, 8'b11_00_11_00, 9, 1, 2'b00);

      // abort in IDLE with same-cycle start: must not load
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(posedge clk); #1;
      chk("idle_abort_busy", int'(bus.busy), 0);

      // reset in the middle of RUN
      clear_events();
      ev_win[0] = 1'b1; ev_win[2] = 1'b1; ev_lose[1] = 1'b1;
      run_session(4'd9, 8'b10_01_11_01, 7, 2, 2'b00);

      // random sessions
      for (int s = 0; s < 30; s++) begin
         clear_events();
         nrun = $urandom_range(1, 45);
         for (int k = 0; k < nrun; k++) begin
            ev_win[k]  = ($urandom_range(0, 3) == 0);
            ev_lose[k] = ($urandom_range(0, 4) == 0);
         end
         endk = ($urandom_range(0, 5) == 0) ? 1 : 0;
         if (($urandom_range(0, 7) == 0) && (nrun >= 2)) endk = 2;
         who = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3))
                                           : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
         run_session(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), nrun, endk, who);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("leftover_load", exp_load.size(), 0);
      chk("leftover_ctrl", exp_ctrl.size(), 0);
      chk("leftover_end", exp_end.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multimode_counter_ctrl.md
Name: multimode_counter_ctrl

Overview:
- Session controller that drives the control side of the multimode counter: mode select bus, parallel-load strobe and load value.
- Consumes the counter's status side: winner/loser pulses, gameover, who and count.
- Sequences a programmed four-step mode schedule, tallies outcome events and reports the final result to the system.
- Sits between the system/host logic and one multimode counter instance.

Parameters:
- CNT_W, 4: counter width; sets the widths of seed, ctr_init_value and ctr_count.
- MODE_CYCLES, 16: RUN cycles spent in each schedule step before advancing; legal range 1..255.
- TALLY_W, 4: width of the saturating win and lose tallies.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  session request; sampled only in IDLE.
- abort  in  1  synchronous abort; overrides everything except rst.
- seed  in  CNT_W  load value, captured when start is accepted.
- mode_seq  in  8  four 2-bit modes; bits [1:0] are step 0, [7:6] are step 3; captured when start is accepted.
- ctr_ctrl  out  2  mode bus to counter: 00 up1, 01 up2, 10 down1, 11 down2.
- ctr_init  out  1  parallel-load strobe to counter.
- ctr_init_value  out  CNT_W  value to load.
- ctr_winner  in  1  counter winner pulse.
- ctr_loser  in  1  counter loser pulse.
- ctr_gameover  in  1  counter gameover flag.
- ctr_who  in  2  counter result: 01 winner, 10 loser.
- ctr_count  in  CNT_W  current counter value; monitored only.
- win_tally  out  TALLY_W  winner pulses seen this session.
- lose_tally  out  TALLY_W  loser pulses seen this session.
- busy  out  1  high from LOAD through DRAIN.
- done  out  1  one-cycle pulse at session end.
- result  out  2  ctr_who sampled in DRAIN; held until next accepted start.
- mismatch  out  1  sticky protocol-error flag; cleared by accepted start or rst.

Behaviour:
- All outputs are registered.
- Reset values: ctr_ctrl=00, ctr_init=0, ctr_init_value=0, tallies=0, busy=0, done=0, result=00, mismatch=0. State resets to IDLE.
- IDLE:
  - start=1 captures seed and mode_seq, clears tallies, result and mismatch, then goes to LOAD.
  - start while not in IDLE is ignored.
- LOAD (exactly 1 cycle):
  - ctr_init=1, ctr_init_value=seed, ctr_ctrl=00.
  - Next state RUN with step=0 and dwell=0.
- RUN:
  - ctr_init=0; ctr_ctrl=mode_seq[2*step+1:2*step].
  - dwell increments each cycle. When dwell reaches MODE_CYCLES-1: dwell returns to 0 and step advances modulo 4 (step 3 wraps to 0).
  - Tally updates:
    - ctr_winner=1 increments win_tally.
    - ctr_loser=1 increments lose_tally.
    - Both tallies saturate at all-ones.
  - ctr_gameover=1 goes to DRAIN. A winner/loser pulse in the same cycle is still counted.
- DRAIN (1 cycle):
  - ctr_ctrl holds its last value.
  - result <= ctr_who.
  - mismatch set if ctr_who is not in {01,10}.
  - Next state DONE.
- DONE (1 cycle): done=1, busy=0, ctr_ctrl=00; next state IDLE.
- mismatch is also set in RUN if ctr_winner and ctr_loser are high in the same cycle.
- ctr_gameover, ctr_winner and ctr_loser are ignored in IDLE and LOAD.
- abort=1 in any state (same-cycle start is ignored):
  - Next state IDLE; ctr_ctrl=00, ctr_init=0, busy=0.
  - done is not pulsed; tallies and result are held.
- rst mid-session returns everything to reset values immediately.

Decomposition:
- Package multimode_pkg holds:
  - state enum {IDLE, LOAD, RUN, DRAIN, DONE};
  - mode constants MODE_UP1=00, MODE_UP2=01, MODE_DN1=10, MODE_DN2=11;
  - who constants WHO_WIN=01, WHO_LOSE=10.
- One sub-module, sat_tally: parameterised saturating counter with clear and increment inputs, instantiated twice (win and lose).

Test Plan:
- Reset: assert rst mid-RUN -> all outputs return to reset values on the same edge; state IDLE; busy=0.
- Basic load: seed=10, mode_seq=8'b11_10_01_00, start pulse -> ctr_init=1 with ctr_init_value=10 for exactly one cycle, then ctr_ctrl=00; busy=1.
- Step rotation (MODE_CYCLES=4) -> ctr_ctrl sequence 00,01,10,11,00 changes every 4 RUN cycles; wraps after step 3.
- Tally and gameover:
  - Stimulus: 3 ctr_winner pulses, 1 ctr_loser pulse, then ctr_gameover=1 with ctr_who=01.
  - Required: win_tally=3, lose_tally=1, result=01, done pulses 2 cycles after gameover, mismatch=0.
- Saturation and error:
  - 20 winner pulses with TALLY_W=4 -> win_tally=15.
  - winner and loser high together -> mismatch=1; it stays set until the next accepted start.
  - gameover with ctr_who=11 -> mismatch=1.
- Abort and ignored start:
  - abort in RUN -> next cycle IDLE, ctr_ctrl=00, no done pulse.
  - start asserted during RUN -> no effect; LOAD is not re-entered.
